mem_board_ctrl: RTL
===================

# mem_board_ctrl

Board/turn-sequencing controller for the two-player memory game. It consumes the turn evaluator's result interface: `x`, `par`, `selected1` and `selected2`. It drives back the `empty` qualifier and the `player` bit that the evaluator samples. It owns the per-card face-up/matched status for a 16-card board. It also holds a mismatched pair visible for a fixed time, then flips it back and passes the turn.

## Interface
- `HOLD_CYCLES`, default 50_000_000: clock cycles a mismatched pair stays face-up; a 1 s display at 50 MHz. Benches override it to a small value such as 8.
- `WAIT_LIMIT`, default 4: maximum cycles to wait for a turn result before aborting.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset. It is sampled on the rising edge of `clk`.
- `select` in 1: card-select strobe, the same signal that feeds the turn evaluator.
- `counter` in 8: cursor card index. Indices 0..15 are valid; 16..255 are never selectable.
- `x` in 2: turn result from the evaluator.
  - 00: idle
  - 01: turn complete
  - 10: winner decided
  - 11: tie
- `par` in 1: pair-match flag. It is valid in the cycle where `x==01`.
- `selected1` in 8: index of the first card of the evaluated turn.
- `selected2` in 8: index of the second card of the evaluated turn.
- `empty` out 1: the card under `counter` may be selected. This output is combinational.
- `player` out 1: active player, 0 or 1.
- `face_up` out 16: bit i set means card i is currently shown.
- `matched` out 16: bit i set means card i has been removed as part of a found pair.
- `busy` out 1: the controller is in WAIT or SHOW.
- `game_over` out 1: sticky; the game has ended.
- `tie` out 1: qualifies `game_over`; 1 means the game ended in a tie.
- `err` out 1: sticky; a turn result timed out.

## Operation
- FSM states: IDLE, ONE_UP, WAIT, SHOW, OVER.
- `empty` = (`counter`<16) && !`face_up[counter]` && !`matched[counter]` && (state is IDLE or ONE_UP). It is 0 in all other states.
- A "pick" is a cycle with `select && empty`.
- IDLE:
  - On a pick, set `face_up[counter]` and go to ONE_UP.
- ONE_UP:
  - On a pick, set `face_up[counter]` and go to WAIT.
- WAIT: load a wait counter with `WAIT_LIMIT` on entry.
  - If `x==01`, latch `par`, `selected1` and `selected2`.
  - If `par==1`: set `matched` for both indices, clear their `face_up` bits, keep `player`, and go to IDLE.
  - If `par==0`: load the hold timer with `HOLD_CYCLES-1` and go to SHOW.
  - If the wait counter expires without `x==01`: clear all `face_up` bits, set `err`, and go to IDLE. `player` is unchanged.
- SHOW:
  - `select` is ignored.
  - When the hold timer reaches 0, clear `face_up` for the latched indices, toggle `player`, and go to IDLE.
- From any state, `x==10` or `x==11` moves to OVER.
  - `game_over` is set to 1 and `tie` is set to (`x==11`).
  - All `face_up` bits are cleared.
  - This takes priority over every other transition in the same cycle.
- OVER is absorbing until reset. In OVER, `empty` is 0.
- A latched index ≥16 updates no bit. No out-of-range indexing is allowed.
- Reset values:
  - state IDLE
  - `face_up`=0, `matched`=0
  - `player`=0
  - `busy`=0, `game_over`=0, `tie`=0, `err`=0
  - hold and wait counters cleared

## Timing
- A pick at edge N shows the card (`face_up` bit set) after edge N.
- The second pick at edge N means the evaluator presents `x==01` after edge N+1.
- WAIT therefore observes the result at edge N+2 and acts on it at that edge.
- A match clears the pair's `face_up` bits and sets their `matched` bits at edge N+2. The next pick is accepted from cycle N+2 on.
- Mismatch timing:
  - The pair stays face-up for exactly `HOLD_CYCLES` cycles in SHOW.
  - `player` toggles and `face_up` clears at the same edge as the SHOW→IDLE transition.
  - With `HOLD_CYCLES`=8, that edge is N+2+8.
- `busy` is a registered output, high exactly while the state is WAIT or SHOW.
- Reset asserted mid-SHOW: all outputs reach their reset values at the next edge. The pending player toggle is discarded.
- A `select` in the same cycle as the SHOW expiry is ignored, because `empty`=0 while in SHOW.
- The hold timer width is $clog2(`HOLD_CYCLES`+1). Its countdown stops at 0 and does not wrap.

## Structure
- Shared package `mem_pkg` holds:
  - `board_state_t`, the enum IDLE/ONE_UP/WAIT/SHOW/OVER
  - `N_CARDS`=16
  - the x codes `X_IDLE`=2'b00, `X_TURN`=2'b01, `X_WIN`=2'b10, `X_TIE`=2'b11
- One sub-module, `hold_timer`: a down-counter with `load`, `load_val`, `en` and a `done` output. One instance is used for SHOW; the WAIT counter stays inline.

## Test plan
- Reset, then `counter`=3 with `select` → `empty`=1 before the edge; after the edge `face_up`=16'h0008 and the state is ONE_UP.
- Pick 3 then 7, then drive `x`=01 with `par`=1, `selected1`=3, `selected2`=7 → `matched`=16'h0088, `face_up`=0, `player`=0. Re-selecting 3 gives `empty`=0.
- Pick 2 then 5, then `x`=01 with `par`=0 (`HOLD_CYCLES`=8) → `face_up`=16'h0024 for 8 cycles with `busy`=1. Then `face_up`=0 and `player`=1, and `select` during SHOW has no effect.
- Pick two cards and never drive `x`=01 → after 4 cycles, `err`=1, `face_up`=0, state IDLE.
- `x`=11 during ONE_UP → `game_over`=1, `tie`=1, `face_up`=0, `empty`=0 for every `counter`. A later `x`=00 keeps OVER.
- Reset asserted in the 3rd SHOW cycle → next edge: all outputs are zero and `player`=0. `counter`=16 gives `empty`=0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-game board controller
package mem_pkg;
  typedef enum logic [2:0] {IDLE, ONE_UP, WAIT, SHOW, OVER} board_state_t;
  localparam int N_CARDS = 16;
  localparam logic [1:0] X_IDLE = 2'b00;
  localparam logic [1:0] X_TURN = 2'b01;
  localparam logic [1:0] X_WIN  = 2'b10;
  localparam logic [1:0] X_TIE  = 2'b11;
  function automatic logic [N_CARDS-1:0] card_bit(input logic [7:0] idx);
    return (idx < 8'(N_CARDS)) ? ({{(N_CARDS-1){1'b0}}, 1'b1} << idx[3:0]) : '0;
  endfunction
endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that saturates at zero and flags done there
module hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
  assign done = (cnt_q == '0);
endmodule

// File: rtl/mem_board_ctrl.sv
// mem_board_ctrl: card status and turn sequencing for the two-player memory game
module mem_board_ctrl
  import mem_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int WAIT_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        select,
  input  logic [7:0]  counter,
  input  logic [1:0]  x,
  input  logic        par,
  input  logic [7:0]  selected1,
  input  logic [7:0]  selected2,
  output logic        empty,
  output logic        player,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic        busy,
  output logic        game_over,
  output logic        tie,
  output logic        err
);
  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  board_state_t state_q, state_d;
  logic [15:0] face_up_q, face_up_d, matched_q, matched_d;
  logic [7:0] sel1_q, sel1_d, sel2_q, sel2_d;
  logic [WW-1:0] wait_q, wait_d;
  logic player_q, player_d, busy_q, game_over_q, game_over_d, tie_q, tie_d, err_q, err_d;
  logic pick, result, ended, wait_exp, hold_load, hold_done;
  assign ended    = (x == X_WIN) || (x == X_TIE);
  assign result   = (x == X_TURN);
  assign wait_exp = (wait_q <= WW'(1));
  assign empty    = (counter < 8'(N_CARDS)) && !face_up_q[counter[3:0]] && !matched_q[counter[3:0]]
                    && (state_q == IDLE || state_q == ONE_UP);
  assign pick     = select && empty;
  hold_timer #(.W(TW)) u_hold (
    .clk(clk), .rst(rst), .load(hold_load), .load_val(TW'(HOLD_CYCLES - 1)),
    .en(state_q == SHOW), .done(hold_done)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      face_up_q   <= '0;
      matched_q   <= '0;
      sel1_q      <= '0;
      sel2_q      <= '0;
      wait_q      <= '0;
      player_q    <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      tie_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      face_up_q   <= face_up_d;
      matched_q   <= matched_d;
      sel1_q      <= sel1_d;
      sel2_q      <= sel2_d;
      wait_q      <= wait_d;
      player_q    <= player_d;
      busy_q      <= (state_d == WAIT) || (state_d == SHOW);
      game_over_q <= game_over_d;
      tie_q       <= tie_d;
      err_q       <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (ended) state_d = OVER;
    else case (state_q)
      IDLE:    if (pick) state_d = ONE_UP;
      ONE_UP:  if (pick) state_d = WAIT;
      WAIT:    if (result) state_d = par ? IDLE : SHOW;
               else if (wait_exp) state_d = IDLE;
      SHOW:    if (hold_done) state_d = IDLE;
      default: state_d = state_q;
    endcase
  end
  // A game-ending result wins over every other board update in the same cycle
  always_comb begin
    face_up_d   = face_up_q;
    matched_d   = matched_q;
    sel1_d      = sel1_q;
    sel2_d      = sel2_q;
    wait_d      = wait_q;
    player_d    = player_q;
    game_over_d = game_over_q;
    tie_d       = tie_q;
    err_d       = err_q;
    hold_load   = 1'b0;
    if (ended) begin
      face_up_d = '0;
      if (state_q != OVER) begin
        game_over_d = 1'b1;
        tie_d       = (x == X_TIE);
      end
    end else case (state_q)
      IDLE: if (pick) face_up_d = face_up_q | card_bit(counter);
      ONE_UP: if (pick) begin
        face_up_d = face_up_q | card_bit(counter);
        wait_d    = WW'(WAIT_LIMIT);
      end
      WAIT: if (result) begin
        sel1_d = selected1;
        sel2_d = selected2;
        if (par) begin
          matched_d = matched_q | card_bit(selected1) | card_bit(selected2);
          face_up_d = face_up_q & ~(card_bit(selected1) | card_bit(selected2));
        end else hold_load = 1'b1;
      end else if (wait_exp) begin
        face_up_d = '0;
        err_d     = 1'b1;
      end else wait_d = wait_q - WW'(1);
      SHOW: if (hold_done) begin
        face_up_d = face_up_q & ~(card_bit(sel1_q) | card_bit(sel2_q));
        player_d  = ~player_q;
      end
      default: ;
    endcase
  end
  assign face_up   = face_up_q;
  assign matched   = matched_q;
  assign player    = player_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;
  assign tie       = tie_q;
  assign err       = err_q;
endmodule
